// File: rtl/verdict_capture_pkg.sv
// ============================================================================
// Module  : verdict_capture_pkg
// Brief   : Shared defaults and record-width helper for the verdict capture slice.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package verdict_capture_pkg;

    localparam int NUM_CH_DEF = 12;
    localparam int DATA_W_DEF = 64;
    localparam int DEPTH_DEF  = 8;
    localparam int TS_W_DEF   = 32;
    localparam int DROP_W     = 16;

    // Packed record layout is {timestamp, activity mask, channel values}.
    function automatic int rec_width(input int num_ch, input int data_w, input int ts_w);
        return ts_w + num_ch + num_ch * data_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/record_fifo.sv
// ============================================================================
// Module  : record_fifo
// Brief   : Show-ahead FIFO; head entry is visible on o_rd_data while non-empty.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module record_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wr_data,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;

endmodule

`default_nettype wire

// File: rtl/verdict_capture.sv
// ============================================================================
// Module  : verdict_capture
// Brief   : Captures active monitor channels into a timestamped record buffer.
//           Define CAPTURE_TIMESTAMP_EN to build the timestamp counter and rec_ts.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module verdict_capture
    import verdict_capture_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int TS_W   = TS_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NUM_CH*DATA_W-1:0]   out_data,
    input  logic [NUM_CH-1:0]          out_aktv,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [NUM_CH*DATA_W-1:0]   rec_data,
    output logic [NUM_CH-1:0]          rec_aktv,
    output logic [TS_W-1:0]            rec_ts,
    output logic [$clog2(DEPTH):0]     level,
    output logic [DROP_W-1:0]          drop_cnt,
    output logic                       overflow
);

`ifdef CAPTURE_TIMESTAMP_EN
    localparam int REC_W = rec_width(NUM_CH, DATA_W, TS_W);
`else
    localparam int REC_W = rec_width(NUM_CH, DATA_W, 0);
`endif
    localparam int VAL_W = NUM_CH * DATA_W;

    logic [REC_W-1:0]  w_wr_rec;
    logic [REC_W-1:0]  w_rd_rec;
    logic              w_full;
    logic              w_empty;
    logic              w_cap;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              r_overflow;

    assign w_cap  = en & (|out_aktv);
    assign w_pop  = rec_valid & rec_ready;
    // A pop on the same edge frees the slot, so a full buffer still accepts.
    assign w_push = w_cap & (~w_full | w_pop);
    assign w_drop = w_cap & w_full & ~w_pop;

`ifdef CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ts <= '0;
        end else if (en) begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    assign w_wr_rec = {r_ts, out_aktv, out_data};
    assign rec_ts   = rec_valid ? w_rd_rec[REC_W-1 -: TS_W] : '0;
`else
    assign w_wr_rec = {out_aktv, out_data};
    assign rec_ts   = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            r_overflow <= 1'b1;
        end
    end

    record_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_wr_data (w_wr_rec),
        .o_rd_data (w_rd_rec),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (level)
    );

    assign rec_valid = ~w_empty;
    assign rec_aktv  = rec_valid ? w_rd_rec[VAL_W +: NUM_CH] : '0;
    assign rec_data  = rec_valid ? w_rd_rec[VAL_W-1:0] : '0;
    assign drop_cnt  = r_drop_cnt;
    assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_verdict_capture.sv
// ============================================================================
// Module  : tb_verdict_capture
// Brief   : Scoreboard bench for verdict_capture (default and TS_W=4 instances).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_verdict_capture;

`ifdef CAPTURE_TIMESTAMP_EN
    localparam bit TS_ON = 1'b1;
`else
    localparam bit TS_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0]  ts;
        logic [11:0]  aktv;
        logic [767:0] data;
    } rec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [767:0] out_data;
    logic [11:0]  out_aktv;
    logic         rec_ready;
    logic         rec_valid;
    logic [767:0] rec_data;
    logic [11:0]  rec_aktv;
    logic [31:0]  rec_ts;
    logic [3:0]   level;
    logic [15:0]  drop_cnt;
    logic         overflow;

    logic         rst4;
    logic         en4;
    logic [15:0]  data4;
    logic [1:0]   aktv4;
    logic         ready4;
    logic         valid4;
    logic [15:0]  rdata4;
    logic [1:0]   raktv4;
    logic [3:0]   rts4;
    logic [2:0]   level4;
    logic [15:0]  drop4;
    logic         ovf4;

    rec_t         q[$];
    int           n_chk  = 0;
    int           n_fail = 0;
    int           cyc    = 0;
    logic [31:0]  mts    = '0;
    logic [15:0]  mdrop  = '0;
    logic         movf   = 1'b0;

    always #5 clk = ~clk;

    verdict_capture dut (
        .clk(clk), .rst(rst), .en(en), .out_data(out_data), .out_aktv(out_aktv),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
        .rec_aktv(rec_aktv), .rec_ts(rec_ts), .level(level),
        .drop_cnt(drop_cnt), .overflow(overflow)
    );

    verdict_capture #(.NUM_CH(2), .DATA_W(8), .DEPTH(4), .TS_W(4)) dut4 (
        .clk(clk), .rst(rst4), .en(en4), .out_data(data4), .out_aktv(aktv4),
        .rec_valid(valid4), .rec_ready(ready4), .rec_data(rdata4),
        .rec_aktv(raktv4), .rec_ts(rts4), .level(level4),
        .drop_cnt(drop4), .overflow(ovf4)
    );

    task automatic chk(input string nm, input logic [767:0] act, input logic [767:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compares the presented head against the scoreboard front.
    always @(negedge clk) begin
        if (rec_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 768'(rec_valid), 768'(0));
            end else begin
                chk("head_data", rec_data, q[0].data);
                chk("head_aktv", 768'(rec_aktv), 768'(q[0].aktv));
                chk("head_ts", 768'(rec_ts), TS_ON ? 768'(q[0].ts) : 768'(0));
            end
        end else begin
            chk("missing_valid", 768'(q.size()), 768'(0));
            chk("idle_zero", {rec_data[767:44], rec_data[43:0] | {rec_aktv, rec_ts}}, 768'(0));
        end
    end

    // Drives one cycle and advances the reference model at the clock edge.
    task automatic cycle(input logic e, input logic [11:0] a, input logic [63:0] v0,
                         input logic r);
        rec_t nr;
        bit   pop;
        en        = e;
        out_aktv  = a;
        out_data  = '0;
        out_data[63:0]    = v0;
        out_data[767:704] = ~v0;
        rec_ready = r;
        nr.ts   = mts;
        nr.aktv = a;
        nr.data = out_data;
        pop = r && (q.size() > 0);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (e && (|a)) begin
            if (q.size() < 8) begin
                q.push_back(nr);
            end else begin
                if (mdrop != 16'hFFFF) mdrop++;
                movf = 1'b1;
            end
        end
        if (e) mts++;
        cyc++;
        #1;
        chk("level", 768'(level), 768'(q.size()));
        chk("drop_cnt", 768'(drop_cnt), 768'(mdrop));
        chk("overflow", 768'(overflow), 768'(movf));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_level", 768'(level), 768'(0));
        chk("rst_valid", 768'(rec_valid), 768'(0));
        chk("rst_overflow", 768'(overflow), 768'(0));
        chk("rst_drop", 768'(drop_cnt), 768'(0));
        chk("rst_data", rec_data, 768'(0));
        q.delete();
        mts   = '0;
        mdrop = '0;
        movf  = 1'b0;
        cyc   = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int c;
        rst = 1'b0; en = 1'b0; out_data = '0; out_aktv = '0; rec_ready = 1'b0;
        rst4 = 1'b0; en4 = 1'b0; data4 = '0; aktv4 = '0; ready4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // First capture at cycle 10 after release.
        for (int i = 0; i < 10; i++) cycle(1'b1, 12'h000, 64'd0, 1'b0);
        cycle(1'b1, 12'h001, 64'd5, 1'b0);
        chk("t37_valid", 768'(rec_valid), 768'(1));
        chk("t37_ts", 768'(rec_ts), TS_ON ? 768'(10) : 768'(0));
        chk("t37_aktv", 768'(rec_aktv), 768'(12'h001));
        chk("t37_val", 768'(rec_data[63:0]), 768'(5));
        cycle(1'b1, 12'h000, 64'd0, 1'b1);

        // Fill to DEPTH, then one more is dropped.
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 12'h001 | (12'h800 >> i), 64'd100 + 64'(i), 1'b0);
        cycle(1'b1, 12'hFFF, 64'd109, 1'b0);
        chk("t38_level", 768'(level), 768'(8));
        chk("t38_drop", 768'(drop_cnt), 768'(1));
        chk("t38_ovf", 768'(overflow), 768'(1));
        chk("t38_head", 768'(rec_data[63:0]), 768'(100));

        // Capture and pop together while full.
        cycle(1'b1, 12'h0F0, 64'd200, 1'b1);
        chk("t39_level", 768'(level), 768'(8));
        chk("t39_drop", 768'(drop_cnt), 768'(1));
        for (int i = 0; i < 7; i++) cycle(1'b1, 12'h000, 64'd0, 1'b1);
        chk("t39_last", 768'(rec_data[63:0]), 768'(200));
        cycle(1'b1, 12'h000, 64'd0, 1'b1);
        chk("t39_empty", 768'(level), 768'(0));

        // Capture and pop together at level 1, with a negative value.
        cycle(1'b1, 12'h001, 64'd300, 1'b0);
        cycle(1'b1, 12'h002, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1);
        chk("t27_level", 768'(level), 768'(1));
        chk("t27_val", 768'(rec_data[63:0]), 768'(64'hFFFF_FFFF_FFFF_FFF0));
        cycle(1'b1, 12'h000, 64'd0, 1'b1);

        // Disabled cycles neither capture nor advance the timestamp.
        for (int i = 0; i < 5; i++) cycle(1'b0, 12'h003, 64'd7, 1'b0);
        chk("t40_nocap", 768'(level), 768'(0));
        c = cyc;
        cycle(1'b1, 12'h003, 64'd8, 1'b0);
        chk("t40_ts", 768'(rec_ts), TS_ON ? 768'(c - 5) : 768'(0));
        cycle(1'b1, 12'h000, 64'd0, 1'b1);

        // Reset with records buffered and overflow set.
        for (int i = 0; i < 3; i++) cycle(1'b1, 12'h010, 64'd400 + 64'(i), 1'b0);
        chk("t41_pre", 768'(level), 768'(3));
        do_reset();
        cycle(1'b1, 12'h004, 64'd9, 1'b0);
        chk("t32_ts0", 768'(rec_ts), 768'(0));
        chk("t32_val", 768'(rec_data[63:0]), 768'(9));
        cycle(1'b1, 12'h000, 64'd0, 1'b1);

        // Narrow timestamp wraps: captures at cycles 15 and 17.
        rst4 = 1'b1;
        en4  = 1'b1;
        for (int k = 0; k < 18; k++) begin
            aktv4 = (k == 15 || k == 17) ? 2'b01 : 2'b00;
            data4 = 16'(k);
            @(posedge clk);
            #1;
        end
        aktv4 = 2'b00;
        chk("t42_level", 768'(level4), 768'(2));
        chk("t42_ts15", 768'(rts4), TS_ON ? 768'(15) : 768'(0));
        ready4 = 1'b1;
        @(posedge clk);
        #1;
        ready4 = 1'b0;
        chk("t42_ts1", 768'(rts4), TS_ON ? 768'(1) : 768'(0));
        chk("t42_val", 768'(rdata4[7:0]), 768'(17));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
